// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: combines stage stall requests
// with EX branch redirects, defers redirects while EX/MEM are frozen, and keeps a watchdog and perf counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_req,
  input  logic [31:0]      branch_target,
  output logic [5:0]       stall,
  output logic [5:0]       flush,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, MEM_WAIT = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic              serviceable;
  logic [5:0]        stall_raw, flush_raw;
  logic              redirect_raw;
  logic [31:0]       redirect_pc_raw;

  assign serviceable = !stallreq_mem && !stallreq_ex;

  // Next state, stall/flush vectors and redirect decision
  always_comb begin
    state_d         = state_q;
    pend_pc_d       = pend_pc_q;
    stall_raw       = 6'b000000;
    flush_raw       = 6'b000000;
    redirect_raw    = 1'b0;
    redirect_pc_raw = 32'h0;

    if (stallreq_mem) begin
      stall_raw = 6'b001111;
      flush_raw = 6'b010000;
    end else if (stallreq_ex) begin
      stall_raw = 6'b000111;
      flush_raw = 6'b001000;
    end else if (stallreq_id) begin
      stall_raw = 6'b000011;
      flush_raw = 6'b000100;
    end else if (stallreq_if) begin
      stall_raw = 6'b000001;
      flush_raw = 6'b000010;
    end

    case (state_q)
      RUN, MEM_WAIT: begin
        if (branch_req) begin
          if (serviceable) begin
            redirect_raw    = 1'b1;
            redirect_pc_raw = branch_target;
            state_d         = RUN;
          end else begin
            pend_pc_d = branch_target;
            state_d   = PEND;
          end
        end else if (stallreq_mem) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      PEND: begin
        if (serviceable) begin
          redirect_raw    = 1'b1;
          redirect_pc_raw = pend_pc_q;
          state_d         = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // A serviced redirect squashes if_id/id_ex and overrides any IF/ID stall
    if (redirect_raw) begin
      stall_raw = 6'b000000;
      flush_raw = 6'b000110;
    end
  end

  // Watchdog and performance counters
  always_comb begin
    wd_cnt_d       = wd_cnt_q;
    timeout_err_d  = timeout_err_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (!stallreq_mem) begin
      wd_cnt_d = '0;
    end else begin
      if (wd_cnt_q == WD_MAX) timeout_err_d = 1'b1;
      else                    wd_cnt_d      = wd_cnt_q + WD_W'(1);
    end
    if (|stall_raw)   stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (redirect_raw) flush_count_d  = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      pend_pc_q      <= 32'h0;
      wd_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pend_pc_q      <= pend_pc_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_err_q  <= timeout_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Zero-latency outputs are forced low while reset is held
  assign stall        = rst ? stall_raw       : 6'b000000;
  assign flush        = rst ? flush_raw       : 6'b000000;
  assign pc_redirect  = rst ? redirect_raw    : 1'b0;
  assign redirect_pc  = rst ? redirect_pc_raw : 32'h0;
  assign timeout_err  = timeout_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic             branch_req;
  logic [31:0]      branch_target;
  logic [5:0]       stall, flush;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_req(branch_req), .branch_target(branch_target),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Behavioural model: a pending-redirect slot, a MEM-stall run length and plain counters
  bit          m_pending;
  logic [31:0] m_pend_pc;
  int unsigned m_mem_run;
  bit          m_err;
  logic [31:0] m_stall_cycles, m_flush_count;

  function automatic int top_source();
    if (stallreq_mem) return 4;
    if (stallreq_ex)  return 3;
    if (stallreq_id)  return 2;
    if (stallreq_if)  return 1;
    return 0;
  endfunction

  function automatic bit exp_service();
    bit ok = !stallreq_mem && !stallreq_ex;
    return ok && (m_pending || branch_req);
  endfunction

  function automatic logic [31:0] exp_target();
    return m_pending ? m_pend_pc : branch_target;
  endfunction

  function automatic logic [5:0] exp_stall();
    int s = top_source();
    if (exp_service() || s == 0) return 6'd0;
    return 6'((1 << s) - 1);
  endfunction

  function automatic logic [5:0] exp_flush();
    int s = top_source();
    if (exp_service()) return 6'b000110;
    if (s == 0) return 6'd0;
    return 6'(1 << s);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending      <= 1'b0;
      m_pend_pc      <= 32'h0;
      m_mem_run      <= 0;
      m_err          <= 1'b0;
      m_stall_cycles <= 32'h0;
      m_flush_count  <= 32'h0;
    end else begin
      if (exp_service()) begin
        m_pending     <= 1'b0;
        m_flush_count <= m_flush_count + 32'd1;
      end else if (!m_pending && branch_req) begin
        m_pending <= 1'b1;
        m_pend_pc <= branch_target;
      end
      if (exp_stall() != 6'd0) m_stall_cycles <= m_stall_cycles + 32'd1;
      // The MEM-wait run counts cycles already waited; the alarm fires on the cycle it sits at TIMEOUT-1
      if (stallreq_mem) begin
        if (m_mem_run >= TIMEOUT - 1) m_err <= 1'b1;
        else                          m_mem_run <= m_mem_run + 1;
      end else begin
        m_mem_run <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("stall",        64'(stall),        64'(exp_stall()));
    chk("flush",        64'(flush),        64'(exp_flush()));
    chk("pc_redirect",  64'(pc_redirect),  64'(exp_service()));
    chk("redirect_pc",  64'(redirect_pc),  exp_service() ? 64'(exp_target()) : 64'h0);
    chk("timeout_err",  64'(timeout_err),  64'(m_err));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cycles));
    chk("flush_count",  64'(flush_count),  64'(m_flush_count));
  endtask

  // Drive one cycle of inputs away from the active edge, then compare after settling
  task automatic step(input bit i_if, input bit i_id, input bit i_ex, input bit i_mem,
                      input bit br, input logic [31:0] tgt);
    @(negedge clk);
    stallreq_if = i_if; stallreq_id = i_id; stallreq_ex = i_ex; stallreq_mem = i_mem;
    branch_req = br; branch_target = tgt;
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stallreq_if = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b1;
    branch_req = 1'b1; branch_target = 32'hDEAD_BEEF;
    #1;
    chk("rst_stall",        64'(stall),        64'h0);
    chk("rst_flush",        64'(flush),        64'h0);
    chk("rst_pc_redirect",  64'(pc_redirect),  64'h0);
    chk("rst_redirect_pc",  64'(redirect_pc),  64'h0);
    chk("rst_timeout_err",  64'(timeout_err),  64'h0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'h0);
    chk("rst_flush_count",  64'(flush_count),  64'h0);
    @(negedge clk);
    stallreq_if = 1'b0; stallreq_mem = 1'b0; branch_req = 1'b0; branch_target = 32'h0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    branch_req = 1'b0; branch_target = 32'h0;
    do_reset();

    step(0, 0, 0, 0, 0, 32'h0);
    chk("idle_stall",    64'(stall),        64'h0);
    chk("idle_flush",    64'(flush),        64'h0);
    chk("idle_counters", 64'(stall_cycles), 64'h0);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 32'h0);
      chk("mem_stall", 64'(stall), 64'h0F);
      chk("mem_flush", 64'(flush), 64'h10);
    end
    step(0, 0, 0, 0, 0, 32'h0);
    chk("mem_stall_cycles", 64'(stall_cycles), 64'd3);
    chk("mem_no_timeout",   64'(timeout_err),  64'd0);

    step(1, 1, 0, 0, 0, 32'h0);
    chk("id_if_stall", 64'(stall), 64'h03);
    chk("id_if_flush", 64'(flush), 64'h04);

    step(0, 1, 0, 0, 1, 32'h0000_0100);
    chk("br_pc_redirect", 64'(pc_redirect), 64'h1);
    chk("br_redirect_pc", 64'(redirect_pc), 64'h100);
    chk("br_flush",       64'(flush),       64'h06);
    chk("br_stall",       64'(stall),       64'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("br_flush_count", 64'(flush_count), 64'd1);

    step(0, 0, 0, 1, 1, 32'h0000_0200);
    chk("pend_no_redirect", 64'(pc_redirect), 64'h0);
    step(0, 0, 0, 1, 1, 32'h0000_0300);
    chk("pend_ignore_2nd", 64'(pc_redirect), 64'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("pend_pc_redirect", 64'(pc_redirect), 64'h1);
    chk("pend_redirect_pc", 64'(redirect_pc), 64'h200);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("pend_once",        64'(pc_redirect), 64'h0);
    chk("pend_flush_count", 64'(flush_count), 64'd2);

    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 32'h0);
    chk("wd_set", 64'(timeout_err), 64'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wd_sticky", 64'(timeout_err), 64'h1);

    step(0, 0, 1, 0, 1, 32'h0000_0400);
    do_reset();
    step(0, 0, 0, 0, 0, 32'h0);
    chk("rst_drop_redirect", 64'(pc_redirect), 64'h0);
    chk("rst_drop_stall",    64'(stall),       64'h0);
    chk("rst_drop_flush",    64'(flush),       64'h0);
    chk("rst_clear_err",     64'(timeout_err), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom);
      if (i == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the five-stage pipeline. It collects stall requests from IF, ID, EX and MEM and branch redirects from EX. It drives the stall[5:0] and flush[5:0] vectors consumed by the PC and the inter-stage registers, and issues PC redirects. It defers branch redirects that arrive while downstream stages are frozen, and keeps a MEM-wait watchdog and stall/flush performance counters.

Parameters:
TIMEOUT, 1024, number of consecutive MEM-stall cycles after which timeout_err is set (must be at least 2)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; asynchronous, active-low
stallreq_if  input  1  IF fetch not ready
stallreq_id  input  1  ID load-use hazard
stallreq_ex  input  1  EX multi-cycle operation busy
stallreq_mem  input  1  MEM access waiting on memory ack
branch_req  input  1  single-cycle pulse from EX: taken branch or jump
branch_target  input  32  redirect PC, valid with branch_req
stall  output  6  index k holds the register after stage k: 0=PC, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb, 5=reserved (always 0)
flush  output  6  index k clears the same register to a bubble; 5 always 0
pc_redirect  output  1  PC loads redirect_pc this cycle
redirect_pc  output  32  redirect target
timeout_err  output  1  sticky watchdog flag
stall_cycles  output  CNT_W  cycles with any stall bit set
flush_count  output  CNT_W  redirects issued

Behaviour:
- While rst is low, all outputs are 0, the FSM is in RUN, and all counters and pending registers are cleared.
- Reset mid-operation drops a pending redirect. The next cycle after release produces no stall or flush.
- stall, flush, pc_redirect and redirect_pc are combinational from the current requests and registered state. A request takes effect in the same cycle, with zero latency.
- Stall rule: the highest active stall source s (IF=1, ID=2, EX=3, MEM=4) sets stall[s-1:0]=1 and flush[s]=1. All other bits are 0.
  - MEM stall gives stall=6'b001111, flush=6'b010000.
  - ID stall gives stall=6'b000011, flush=6'b000100.
- Priority is MEM > EX > ID > IF.
- Redirect rule: a redirect is serviceable when stallreq_mem=0 and stallreq_ex=0. When serviced:
  - pc_redirect=1.
  - flush[2:1]=2'b11, so if_id and id_ex are cleared.
  - stall=0. An IF or ID stall in the same cycle is overridden.
  - flush_count increments.
- FSM states:
  - RUN: a branch_req that is serviceable is serviced immediately, with redirect_pc=branch_target, and the FSM stays in RUN. A branch_req that is not serviceable latches branch_target into pend_pc and moves to PEND. If stallreq_mem=1 (without a redirect), go to MEM_WAIT.
  - PEND: the stall rule applies normally. In the first cycle that the redirect is serviceable, service it with redirect_pc=pend_pc, then return to RUN.
  - PEND also handles these cases:
    - A branch_req arriving while in PEND is ignored; the first target wins.
    - The watchdog keeps counting while in PEND.
  - MEM_WAIT: wd_cnt increments each cycle that stallreq_mem=1. When stallreq_mem=0, clear wd_cnt and return to RUN. A branch_req in MEM_WAIT behaves as in RUN with non-serviceable conditions: latch the target and go to PEND. The watchdog count is kept in a separate register that is cleared whenever stallreq_mem=0, in any state.
- Watchdog: when wd_cnt reaches TIMEOUT-1 while stallreq_mem=1, set timeout_err. It stays set until reset. wd_cnt saturates and does not wrap.
- Counters: stall_cycles increments on every cycle with |stall=1. Both counters wrap modulo 2^CNT_W.
- Outside a serviced redirect cycle, redirect_pc=0.

Test Plan:
- Reset release, no requests -> stall=0, flush=0, pc_redirect=0, counters=0.
- stallreq_mem=1 for 3 cycles -> stall=6'b001111 and flush=6'b010000 each cycle; stall_cycles=3.
- stallreq_id=1 together with stallreq_if=1 -> stall=6'b000011, flush=6'b000100.
- branch_req with target 0x0000_0100 and stallreq_id=1 -> same cycle: pc_redirect=1, redirect_pc=0x100, flush=6'b000110, stall=0; flush_count=1.
- branch_req with target 0x200 during a MEM stall, stall drops 2 cycles later -> no redirect during the stall; then one cycle with pc_redirect=1 and redirect_pc=0x200. A second branch_req with target 0x300 while pending is ignored.
- TIMEOUT=4, stallreq_mem held 6 cycles -> timeout_err rises by cycle 4 and stays 1 after the stall clears. Asserting rst mid-PEND -> no redirect issued after release.
